// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encodings,
// flush/watchdog counter widths and a saturating increment helper.
package pipe_ctrl_pkg;

  // Width of the post-jump bubble counter (FLUSH_CYCLES up to 15).
  localparam int CTRL_FLUSH_CNT_W = 4;

  // Width of the hold watchdog counter (HOLD_TIMEOUT up to 65535).
  localparam int CTRL_WDOG_W = 16;

  // Control FSM states. Encodings are fixed so debug probes can decode them.
  typedef enum logic [1:0] {
    CTRL_ST_RUN   = 2'd0,
    CTRL_ST_FLUSH = 2'd1,
    CTRL_ST_HOLD  = 2'd2
  } ctrl_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CTRL_WDOG_W-1:0] wdog_sat_inc(
    input logic [CTRL_WDOG_W-1:0] value
  );
    logic [CTRL_WDOG_W-1:0] result;
    if (value == {CTRL_WDOG_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CTRL_WDOG_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// ctrl_wdog: counts consecutive stall cycles with a saturating 16-bit counter
// and raises a sticky timeout flag once the count reaches HOLD_TIMEOUT.
// Any non-stall cycle clears the count; only reset clears the flag.
module ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  localparam logic [CTRL_WDOG_W-1:0] LIMIT = CTRL_WDOG_W'(HOLD_TIMEOUT);

  logic [CTRL_WDOG_W-1:0] cnt_q;
  logic [CTRL_WDOG_W-1:0] cnt_next;
  logic                   timeout_q;

  // Next stall count: grow while stalled (saturating), clear otherwise.
  always_comb begin
    cnt_next = '0;
    if (stall) begin
      cnt_next = wdog_sat_inc(cnt_q);
    end
  end

  // Count register and sticky flag; the flag sets on the edge that brings
  // the count to the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      if (stall && (cnt_next >= LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit. Turns execute-stage redirect/hold requests
// and an external bus-wait request into the PC redirect, the if_id/id_ex flush
// and the pc_reg/if_id/id_ex stall. Runs a RUN/FLUSH/HOLD FSM that stretches
// the flush over FLUSH_CYCLES cycles after a taken jump, plus a hold watchdog.
// Optional build macro CTRL_PERF_CNT_EN adds jump and stall-cycle counters;
// without it the perf ports read 0 and no counter flops exist.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        hold_req_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        hold_timeout_o,
  output logic [31:0] perf_jumps_o,
  output logic [31:0] perf_stalls_o
);

  // Counter value loaded on a taken jump: the jump cycle itself is the
  // first flush cycle, so FLUSH covers the remaining FLUSH_CYCLES-1.
  localparam logic [CTRL_FLUSH_CNT_W-1:0] FLUSH_LOAD =
    CTRL_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  // state_q is the FSM state register; probe it by name when debugging.
  ctrl_state_e                 state_q;
  ctrl_state_e                 state_d;
  logic [CTRL_FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [CTRL_FLUSH_CNT_W-1:0] flush_cnt_d;

  logic hold_any;
  logic run_eval;
  logic jump_c;
  logic flush_c;
  logic stall_c;

  assign hold_any = hold_flag_i | hold_req_i;

  // Next-state and strobe decode. HOLD falls through to RUN rules in the
  // cycle the holds drop, so a waiting jump is taken with no extra cycle.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    jump_c      = 1'b0;
    flush_c     = 1'b0;
    stall_c     = 1'b0;
    run_eval    = 1'b0;

    case (state_q)
      CTRL_ST_FLUSH: begin
        // Execute holds a bubble here, so jump and exec hold are ignored.
        flush_c = 1'b1;
        if (hold_req_i) begin
          stall_c = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - {{(CTRL_FLUSH_CNT_W-1){1'b0}}, 1'b1};
          if (flush_cnt_q <= {{(CTRL_FLUSH_CNT_W-1){1'b0}}, 1'b1}) begin
            state_d     = CTRL_ST_RUN;
            flush_cnt_d = '0;
          end
        end
      end
      CTRL_ST_HOLD: begin
        if (hold_any) begin
          stall_c = 1'b1;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: begin
        run_eval = 1'b1;
      end
    endcase

    if (run_eval) begin
      state_d = CTRL_ST_RUN;
      if (jump_en_i) begin
        // A jump wins over a same-cycle hold request.
        jump_c  = 1'b1;
        flush_c = 1'b1;
        if (MULTI_FLUSH) begin
          state_d     = CTRL_ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end else if (hold_any) begin
        stall_c = 1'b1;
        state_d = CTRL_ST_HOLD;
      end
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CTRL_ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Strobes are forced low while reset is asserted, even if inputs are live.
  assign jump_en_o   = jump_c & ~rst;
  assign jump_addr_o = jump_en_o ? jump_addr_i : 32'd0;
  assign flush_o     = flush_c & ~rst;
  assign stall_o     = stall_c & ~rst;

  ctrl_wdog #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall_o),
    .timeout (hold_timeout_o)
  );

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_jumps_q;
  logic [31:0] perf_stalls_q;

  // Free-running event counters; they wrap modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jumps_q  <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      if (jump_en_o) begin
        perf_jumps_q <= perf_jumps_q + 32'd1;
      end
      if (stall_o) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_jumps_o  = perf_jumps_q;
  assign perf_stalls_o = perf_stalls_q;
`else
  assign perf_jumps_o  = 32'd0;
  assign perf_stalls_o = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Pipeline control unit. Consumes the execute stage's redirect and hold requests (`jump_en`, `jump_addr`, `hold_flag`) plus an external bus-wait request.
- Drives the PC redirect, the flush of `if_id`/`id_ex`, and the stall of `pc_reg`/`if_id`/`id_ex`.
- Owns the multi-cycle bubble-insertion counter after a taken jump/branch and a hold watchdog.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` is asserted per taken jump, counting the jump cycle. Legal range 1..15.
- `HOLD_TIMEOUT`, default 255: consecutive stall cycles before the watchdog fires. Legal range 1..65535.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous and active-high.
- `jump_en_i` in 1: taken jump/branch from execute.
- `jump_addr_i` in 32: redirect target from execute.
- `hold_flag_i` in 1: execute-stage hold request (multi-cycle op).
- `hold_req_i` in 1: external hold request (memory/bus wait).
- `jump_en_o` out 1: redirect strobe to `pc_reg`.
- `jump_addr_o` out 32: redirect target to `pc_reg`.
- `flush_o` out 1: zero `if_id` and `id_ex` contents (insert NOP) on the next edge.
- `stall_o` out 1: freeze `pc_reg`, `if_id` and `id_ex`.
- `hold_timeout_o` out 1: sticky watchdog flag.
- `perf_jumps_o` out 32: taken-jump counter (`CTRL_PERF_CNT_EN` only).
- `perf_stalls_o` out 32: stall-cycle counter (`CTRL_PERF_CNT_EN` only).

## Operation
- FSM states: RUN, FLUSH, HOLD. Reset state is RUN, flush counter 0.
- While `rst`=1 every output is 0.

RUN:
- If `jump_en_i`=1:
  - `jump_en_o`=1, `jump_addr_o`=`jump_addr_i`, `flush_o`=1, `stall_o`=0. This is combinational, the same cycle.
  - Any `hold_flag_i` in the same cycle is ignored.
  - If `FLUSH_CYCLES`>1, load the counter with `FLUSH_CYCLES`-1 and go to FLUSH. Otherwise stay in RUN.
- Else if `hold_flag_i`|`hold_req_i`: `stall_o`=1, go to HOLD.
- Else all strobes are 0.

FLUSH:
- `flush_o`=1.
- `jump_en_i` and `hold_flag_i` are masked, because execute holds a bubble.
- If `hold_req_i`=1: `stall_o`=1 and the counter freezes.
- Otherwise the counter decrements. When it reaches 0, go to RUN in the same edge. The last flush cycle has counter=1.

HOLD:
- `stall_o`=1 while `hold_flag_i`|`hold_req_i`.
- `jump_en_i` is masked while stalled.
- In the first cycle where both holds are 0, the FSM returns to RUN and that cycle is evaluated with RUN rules. A pending `jump_en_i` is honored in that same cycle.

Watchdog:
- A 16-bit counter increments every cycle `stall_o`=1 and clears on any non-stall cycle.
- When it reaches `HOLD_TIMEOUT`, `hold_timeout_o` is set and stays 1 until `rst`.
- The counter saturates; it never wraps.

`jump_addr_o` is 0 whenever `jump_en_o`=0.

## Timing
- Redirect latency is 0 cycles: `jump_en_o`/`jump_addr_o`/`flush_o` are combinational from `jump_en_i` in RUN.
- `flush_o` stays high for exactly `FLUSH_CYCLES` unstalled cycles, plus any cycles frozen by `hold_req_i`.
- `stall_o` asserts in the same cycle as the hold request and deasserts in the same cycle the request drops.
- `hold_timeout_o` rises on the edge where the stall count equals `HOLD_TIMEOUT`.
- Reset mid-FLUSH or mid-HOLD: asynchronous return to RUN; the counter, watchdog and perf counters clear.

## Configuration
Macro `CTRL_PERF_CNT_EN`.

When defined:
- `perf_jumps_o` increments on each cycle with `jump_en_o`=1.
- `perf_stalls_o` increments on each cycle with `stall_o`=1.
- Both wrap modulo 2^32 and reset to 0.

When undefined:
- Both ports remain and are tied to 0.
- No counter flops are synthesized.

## Structure
- Shared package/defines header holds:
  - FSM state encodings `CTRL_ST_RUN`=2'd0, `CTRL_ST_FLUSH`=2'd1, `CTRL_ST_HOLD`=2'd2.
  - Flush counter width 4.
  - Watchdog width 16.
- One sub-module: `ctrl_wdog`, the saturating stall counter plus sticky timeout flag, parameterized by `HOLD_TIMEOUT`.

## Test plan
- Jump in RUN: `jump_en_i`=1, `jump_addr_i`=0x0000_0040 for 1 cycle with default parameters -> `jump_en_o`=1 and `jump_addr_o`=0x40 that cycle. `flush_o`=1 for 2 cycles, then RUN with `flush_o`=0.
- Exec hold: `hold_flag_i`=1 for 5 cycles -> `stall_o`=1 for exactly those 5 cycles, `flush_o`=0. With `CTRL_PERF_CNT_EN`, `perf_stalls_o`=5.
- Simultaneous jump and hold: `jump_en_i`=1 and `hold_flag_i`=1 in the same cycle -> redirect taken, `stall_o`=0, FSM goes to FLUSH.
- External hold mid-flush: `FLUSH_CYCLES`=3, `hold_req_i`=1 for 2 cycles starting at the second flush cycle -> `flush_o` high for 5 cycles total, with `stall_o`=1 during the middle two.
- Watchdog: `HOLD_TIMEOUT`=4, `hold_req_i` held for 6 cycles -> `hold_timeout_o` rises after the 4th stall cycle and stays 1 after the request drops, until `rst`.
- Reset mid-FLUSH: assert `rst` in the first FLUSH cycle -> all outputs 0 immediately. After release the FSM is in RUN and the perf counters are 0.
